// File: rtl/uart_imem_loader_if.sv
// ----------------------------------------------------------------------------
// uart_imem_loader_if
//   Bundles the two data paths of the boot loader:
//     rx side  : rx_msg[7:0], rx_complete   (UART receiver -> loader)
//     mem side : mem_we, mem_addr[ADDR_W-1:0], mem_wdata[31:0]
//                (loader -> instruction memory)
//   Modports:
//     master : the environment around the loader (drives rx, observes mem)
//     slave  : the loader itself (observes rx, drives mem)
//
// Handshake semantics:
//   rx_complete is a level flag with no back-pressure. The loader takes one
//   byte from rx_msg on each rising edge of rx_complete (a level held high is
//   one byte). mem_we is a one-cycle write strobe with no ready; the memory
//   must accept mem_addr/mem_wdata in every cycle where mem_we is high.
//   mem_addr/mem_wdata hold their last values while mem_we is low.
// ----------------------------------------------------------------------------
interface uart_imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_msg;
  logic              rx_complete;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_msg,
    output rx_complete,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_msg,
    input  rx_complete,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// ----------------------------------------------------------------------------
// uart_imem_loader
//   Boot-time loader behind the UART receiver. Parses a length-prefixed frame
//   (LEN_LO, LEN_HI, then N little-endian 32-bit words) and writes the words
//   sequentially into instruction memory starting at address 0. The CPU is
//   held in reset until a frame has been loaded cleanly.
//
//   Optional feature macro: LOADER_CSUM_EN
//     When defined, one checksum byte (XOR of all data bytes) follows the
//     data; a mismatch ends in the error state.
//
// Ports:
//   clk_50M    in   50 MHz clock, rising edge
//   rst        in   synchronous active-high reset
//   bus        if   uart_imem_loader_if.slave (rx byte in, memory write out)
//   busy       out  frame in progress
//   done       out  sticky: frame loaded successfully
//   err        out  sticky: length, timeout or checksum failure
//   cpu_hold   out  keeps the CPU in reset while high
//   word_count out  words written so far (ADDR_W+1 bits)
//   state_o    out  current FSM state (debug)
// ----------------------------------------------------------------------------
module uart_imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk_50M,
  input  logic              rst,
  uart_imem_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        state_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Where the frame goes once all data (or a zero length) has been consumed.
`ifdef LOADER_CSUM_EN
  localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
  localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

  logic              rx_d_q;
  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              strobe;
  logic              timed;
  logic              expire;
  logic [15:0]       new_len;
  logic [ADDR_W:0]   wc_inc;

  // Rising edge of rx_complete; a held level produces a single byte.
  assign strobe  = bus.rx_complete & ~rx_d_q;
  assign new_len = {bus.rx_msg, len_q[7:0]};
  assign wc_inc  = wc_q + {{ADDR_W{1'b0}}, 1'b1};

  // The inter-byte timer only runs while a frame is partially received.
`ifdef LOADER_CSUM_EN
  assign timed = (state_q == S_LEN1) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign timed = (state_q == S_LEN1) || (state_q == S_DATA);
`endif

  // Expiry is the edge on which the counter would reach TIMEOUT_CYC; a strobe
  // on that same edge takes priority and keeps the frame alive.
  assign expire = timed && !strobe && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    word_buf_d  = word_buf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wc_d        = wc_q;
`ifdef LOADER_CSUM_EN
    csum_d      = csum_q;
`endif

    if (!timed || strobe) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      S_LEN0: begin
        if (strobe) begin
          len_d   = {8'h00, bus.rx_msg};
          state_d = S_LEN1;
        end
      end

      S_LEN1: begin
        if (strobe) begin
          len_d      = new_len;
          byte_idx_d = 2'd0;
          if (32'(new_len) > CAPACITY) begin
            state_d = S_ERR;
          end else if (new_len == 16'd0) begin
            state_d = S_AFTER_DATA;
          end else begin
            state_d = S_DATA;
          end
        end else if (expire) begin
          state_d = S_ERR;
        end
      end

      S_DATA: begin
        if (strobe) begin
`ifdef LOADER_CSUM_EN
          csum_d = csum_q ^ bus.rx_msg;
`endif
          if (byte_idx_q == 2'd3) begin
            // Fourth byte: register the whole word so the write strobe
            // appears in the cycle right after the accepting edge.
            mem_we_d    = 1'b1;
            mem_wdata_d = {bus.rx_msg, word_buf_q};
            mem_addr_d  = wc_q[ADDR_W-1:0];
            wc_d        = wc_inc;
            byte_idx_d  = 2'd0;
            if (32'(wc_inc) == 32'(len_q)) begin
              state_d = S_AFTER_DATA;
            end
          end else begin
            word_buf_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_msg;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else if (expire) begin
          state_d = S_ERR;
        end
      end

`ifdef LOADER_CSUM_EN
      S_CSUM: begin
        if (strobe) begin
          state_d = (bus.rx_msg == csum_q) ? S_DONE : S_ERR;
        end else if (expire) begin
          state_d = S_ERR;
        end
      end
`endif

      S_DONE: begin
        state_d = S_DONE;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      rx_d_q      <= 1'b0;
      state_q     <= S_LEN0;
      len_q       <= '0;
      byte_idx_q  <= '0;
      word_buf_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wc_q        <= '0;
      to_cnt_q    <= '0;
`ifdef LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      rx_d_q      <= bus.rx_complete;
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      word_buf_q  <= word_buf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wc_q        <= wc_d;
      to_cnt_q    <= to_cnt_d;
`ifdef LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign busy       = (state_q != S_LEN0) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign cpu_hold   = (state_q != S_DONE);
  assign word_count = wc_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_uart_imem_loader
//   Directed and randomized frames against a byte-position reference model.
//   The model works from frame layout (header, data words, optional checksum)
//   and an idle-edge count since the last accepted byte. Expected memory
//   writes go into exp_q and are popped when the DUT strobes mem_we.
// ----------------------------------------------------------------------------
module tb_uart_imem_loader;
  localparam int ADDR_W = 10;
  localparam int TO     = 200;
  localparam int CAP    = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  uart_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  logic            busy, done, err, cpu_hold;
  logic [ADDR_W:0] word_count;
  logic [2:0]      state_o;

  uart_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk_50M    (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold),
    .word_count (word_count),
    .state_o    (state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0]         tx_q[$];

  // Reference model of one frame.
  int         m_pos;    // bytes accepted in this frame
  int         m_lo;     // LEN_LO
  int         m_n;      // word count from header
  int         m_fin;    // 0 running, 1 done, 2 error
  int         m_wc;     // words written
  int         m_wr;     // writes expected since reset
  int         m_since;  // non-accepting edges since last accepted byte
  logic [31:0] m_word;
  logic [7:0]  m_csum;

  int wr_seen = 0;
  int wr_base = 0;
  always @(negedge clk) if (bus.mem_we === 1'b1) wr_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_lo = 0; m_n = 0; m_fin = 0; m_wc = 0; m_wr = 0;
    m_since = 0; m_word = '0; m_csum = '0;
  endfunction

  function automatic void model_idle(input int n);
    m_since += n;
    if (m_pos >= 1 && m_fin == 0 && m_since >= TO) m_fin = 2;
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    int p, k;
    if (m_fin == 0) begin
      p = m_pos;
      m_pos++;
      m_since = 0;
      if (p == 0) begin
        m_lo = int'(b);
      end else if (p == 1) begin
        m_n = int'(b) * 256 + m_lo;
        if (m_n > CAP) m_fin = 2;
`ifndef LOADER_CSUM_EN
        else if (m_n == 0) m_fin = 1;
`endif
      end else if (p < 2 + 4 * m_n) begin
        k = (p - 2) % 4;
        m_word[8*k +: 8] = b;
        m_csum ^= b;
        if (k == 3) begin
          exp_q.push_back({ADDR_W'((p - 2) / 4), m_word});
          m_wc++;
          m_wr++;
`ifndef LOADER_CSUM_EN
          if (m_wc == m_n) m_fin = 1;
`endif
        end
      end else begin
        m_fin = (b == m_csum) ? 1 : 2;
      end
    end
  endfunction

  // ---------------- driver tasks (enter/leave just after a negedge) --------
  task automatic check_write();
    logic [ADDR_W+31:0] e;
    logic pending;
    pending = (exp_q.size() != 0);
    chk("mem_we", bus.mem_we, pending);
    if (pending) begin
      e = exp_q.pop_front();
      chk("mem_addr", bus.mem_addr, e[ADDR_W+31:32]);
      chk("mem_wdata", bus.mem_wdata, e[31:0]);
    end
    chk("done_lat", done, m_fin == 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    model_idle(n);
  endtask

  task automatic hold_byte(input logic [7:0] b, input int n);
    bus.rx_msg = b;
    bus.rx_complete = 1'b1;
    @(negedge clk);
    model_accept(b);
    check_write();
    repeat (n - 1) @(negedge clk);
    model_idle(n - 1);
    bus.rx_complete = 1'b0;
    @(negedge clk);
    chk("we_pulse", bus.mem_we, 0);
    model_idle(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    hold_byte(b, 1);
  endtask

  task automatic send_all();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front());
  endtask

  task automatic check_status(input string tag);
    #1;
    chk({tag, ".busy"}, busy, (m_pos >= 1) && (m_fin == 0));
    chk({tag, ".done"}, done, m_fin == 1);
    chk({tag, ".err"}, err, m_fin == 2);
    chk({tag, ".cpu_hold"}, cpu_hold, m_fin != 1);
    chk({tag, ".word_count"}, word_count, m_wc);
    chk({tag, ".writes"}, wr_seen - wr_base, m_wr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_complete = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    wr_base = wr_seen;
    chk("rst.mem_we", bus.mem_we, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    chk("rst.mem_wdata", bus.mem_wdata, 0);
    check_status("rst");
  endtask

  function automatic logic [7:0] data_xor();
    logic [7:0] x = 8'h00;
    for (int i = 2; i < tx_q.size(); i++) x ^= tx_q[i];
    return x;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, g;
    bus.rx_msg = 8'h00;
    bus.rx_complete = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // Two-word example frame.
    tx_q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CSUM_EN
    tx_q.push_back(8'h7C);
`endif
    send_all();
    check_status("frame2");
    chk("frame2.done_const", done, 1);
    chk("frame2.wc_const", word_count, 2);

`ifdef LOADER_CSUM_EN
    do_reset();
    tx_q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7D};
    send_all();
    check_status("bad_csum");
`endif

    // Length one beyond capacity, then a further strobe that must be ignored.
    do_reset();
    tx_q = {8'h01, 8'h04};
    send_all();
    check_status("too_long");
    send_byte(8'h55);
    check_status("too_long_after");

    // Zero-length frame.
    do_reset();
    tx_q = {8'h00, 8'h00};
`ifdef LOADER_CSUM_EN
    tx_q.push_back(8'h00);
`endif
    send_all();
    check_status("zero_len");

    // Timeout mid-word.
    do_reset();
    tx_q = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_all();
    idle(TO);
    check_status("timeout");

    // Next byte lands exactly on the expiry edge: strobe wins.
    do_reset();
    tx_q = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_all();
    idle(TO - 2);
    tx_q = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    void'(tx_q.pop_front()); void'(tx_q.pop_front());
    void'(tx_q.pop_front()); void'(tx_q.pop_front());
    send_all();
`ifdef LOADER_CSUM_EN
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
    check_status("expiry_edge");

    // Level held high for 20 cycles counts as one byte.
    do_reset();
    tx_q = {8'h01, 8'h00};
    send_all();
    hold_byte(8'h11, 20);
    tx_q = {8'h22, 8'h33, 8'h44};
    send_all();
`ifdef LOADER_CSUM_EN
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    check_status("held_level");

    // Reset after three data bytes, then a fresh frame.
    do_reset();
    tx_q = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    send_all();
    do_reset();
    tx_q = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef LOADER_CSUM_EN
    tx_q.push_back(8'h04);
`endif
    send_all();
    check_status("after_rst");

    // Randomized short frames with random gaps (some at or past the timeout).
    for (int f = 0; f < 10; f++) begin
      do_reset();
      n = $urandom_range(0, 6);
      tx_q = {8'(n), 8'h00};
      for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CSUM_EN
      tx_q.push_back((f == 3) ? (data_xor() ^ 8'h01) : data_xor());
`endif
      while (tx_q.size() != 0) begin
        send_byte(tx_q.pop_front());
        case ($urandom_range(0, 9))
          0: g = TO - 2;
          1: g = (f >= 6) ? TO - 1 : 0;
          default: g = $urandom_range(0, 4);
        endcase
        idle(g);
      end
      check_status("rand");
    end

    // Full-capacity frame: last write at the top address, word_count = 2^ADDR_W.
    do_reset();
    tx_q = {8'h00, 8'h04};
    for (int i = 0; i < 4 * CAP; i++) tx_q.push_back(8'($urandom_range(0, 255)));
`ifdef LOADER_CSUM_EN
    tx_q.push_back(data_xor());
`endif
    send_all();
    check_status("full");
    chk("full.wc_const", word_count, CAP);
    send_byte(8'h99);
    check_status("full_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
